// File: rtl/sensor_fifo_param.sv
// Parametrised single-clock FWFT sample FIFO with count, watermark, flush and sticky errors.
// Define SENSOR_FIFO_OVERWRITE_OLDEST_EN for ring-buffer mode (write while full drops the oldest).
module sensor_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_command,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     read_command,
  input  logic                     flush,
  input  logic                     err_clear,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic wr_en, rd_en, drop_oldest;
  logic ovf_evt, udf_evt;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_THRESH));
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
  assign read_data   = fifo_empty ? '0 : mem[rd_ptr_q];

  assign ovf_evt = write_command && fifo_full && !read_command;
  assign udf_evt = read_command && fifo_empty;
  assign rd_en   = read_command && !fifo_empty;

`ifdef SENSOR_FIFO_OVERWRITE_OLDEST_EN
  // Full write without a read pushes the read pointer along with it.
  assign wr_en       = write_command;
  assign drop_oldest = ovf_evt;
`else
  assign wr_en       = write_command && (!fifo_full || read_command);
  assign drop_oldest = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en || drop_oldest) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !rd_en && !drop_oldest) begin
        count_d = count_q + CW'(1);
      end else if (rd_en && !wr_en) begin
        count_d = count_q - CW'(1);
      end
    end

    if (err_clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (udf_evt) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr_q] <= write_data;
  end

endmodule
